// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared dispatch state encoding and default sizing for the kernel dispatcher
package gpu_pkg;

  localparam int DEFAULT_WIDTH           = 16;
  localparam int DEFAULT_WATCHDOG_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_RUN     = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_FIN     = 3'd4
  } dispatch_state_t;

endpackage

// File: rtl/watchdog_timer.sv
// rtl/watchdog_timer.sv - per-thread RUN cycle counter; expired flags the last permitted cycle
module watchdog_timer #(
  parameter int CYCLES = gpu_pkg::DEFAULT_WATCHDOG_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/kernel_dispatcher.sv
// rtl/kernel_dispatcher.sv - walks a block x thread grid, launching the core once per thread
module kernel_dispatcher #(
  parameter int WIDTH           = gpu_pkg::DEFAULT_WIDTH,
  parameter int WATCHDOG_CYCLES = gpu_pkg::DEFAULT_WATCHDOG_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] num_blocks,
  input  logic [WIDTH-1:0] block_dim_in,
  input  logic [WIDTH-1:0] base_pc,
  input  logic             abort,
  input  logic             core_done,
  output logic             core_launch,
  output logic [WIDTH-1:0] core_pc,
  output logic [WIDTH-1:0] block_idx,
  output logic [WIDTH-1:0] block_dim,
  output logic [WIDTH-1:0] thread_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  import gpu_pkg::*;

  dispatch_state_t  state_q, state_d;
  logic [WIDTH-1:0] num_blocks_q, num_blocks_d;
  logic [WIDTH-1:0] block_dim_q, block_dim_d;
  logic [WIDTH-1:0] core_pc_q, core_pc_d;
  logic [WIDTH-1:0] block_idx_q, block_idx_d;
  logic [WIDTH-1:0] thread_idx_q, thread_idx_d;
  logic             err_q, err_d;
  logic             wd_clear, wd_enable, wd_expired;
  logic             last_thread, last_block;

  watchdog_timer #(
    .CYCLES (WATCHDOG_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  assign last_thread = (thread_idx_q == block_dim_q - WIDTH'(1));
  assign last_block  = (block_idx_q == num_blocks_q - WIDTH'(1));

  always_comb begin
    state_d      = state_q;
    num_blocks_d = num_blocks_q;
    block_dim_d  = block_dim_q;
    core_pc_d    = core_pc_q;
    block_idx_d  = block_idx_q;
    thread_idx_d = thread_idx_q;
    err_d        = err_q;
    wd_clear     = 1'b0;
    wd_enable    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_blocks_d = num_blocks;
          block_dim_d  = block_dim_in;
          core_pc_d    = base_pc;
          block_idx_d  = '0;
          thread_idx_d = '0;
          err_d        = 1'b0;
          state_d      = (num_blocks == '0 || block_dim_in == '0) ? ST_FIN : ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wd_clear = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (core_done) begin
          state_d = ST_ADVANCE;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          wd_enable = 1'b1;
        end
      end
      ST_ADVANCE: begin
        if (!last_thread) begin
          thread_idx_d = thread_idx_q + WIDTH'(1);
          state_d      = ST_LAUNCH;
        end else if (!last_block) begin
          thread_idx_d = '0;
          block_idx_d  = block_idx_q + WIDTH'(1);
          state_d      = ST_LAUNCH;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides whatever the state decided, including a same-cycle timeout.
    if (abort && state_q != ST_IDLE) begin
      state_d      = ST_IDLE;
      err_d        = err_q;
      block_idx_d  = block_idx_q;
      thread_idx_d = thread_idx_q;
      wd_enable    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      num_blocks_q <= '0;
      block_dim_q  <= '0;
      core_pc_q    <= '0;
      block_idx_q  <= '0;
      thread_idx_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_blocks_q <= num_blocks_d;
      block_dim_q  <= block_dim_d;
      core_pc_q    <= core_pc_d;
      block_idx_q  <= block_idx_d;
      thread_idx_q <= thread_idx_d;
      err_q        <= err_d;
    end
  end

  assign core_launch = (state_q == ST_LAUNCH);
  assign done        = (state_q == ST_FIN);
  assign busy        = (state_q != ST_IDLE);
  assign core_pc     = core_pc_q;
  assign block_idx   = block_idx_q;
  assign block_dim   = block_dim_q;
  assign thread_idx  = thread_idx_q;
  assign err         = err_q;

endmodule

// File: tb/tb_kernel_dispatcher.sv
// tb/tb_kernel_dispatcher.sv - scoreboard bench for kernel_dispatcher
module tb_kernel_dispatcher;

  localparam int W  = 16;
  localparam int WD = 8;

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic [W-1:0] num_blocks, block_dim_in, base_pc;
  logic         core_done_model, core_done_stray, core_done;
  logic         core_launch, busy, done, err;
  logic [W-1:0] core_pc, block_idx, block_dim, thread_idx;

  assign core_done = core_done_model | core_done_stray;

  kernel_dispatcher #(
    .WIDTH           (W),
    .WATCHDOG_CYCLES (WD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_blocks   (num_blocks),
    .block_dim_in (block_dim_in),
    .base_pc      (base_pc),
    .abort        (abort),
    .core_done    (core_done),
    .core_launch  (core_launch),
    .core_pc      (core_pc),
    .block_idx    (block_idx),
    .block_dim    (block_dim),
    .thread_idx   (thread_idx),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] b;
    logic [W-1:0] t;
    logic [W-1:0] pc;
    logic [W-1:0] dim;
  } launch_t;

  launch_t exp_launch[$];
  logic    exp_done_err[$];
  launch_t mon_e;
  logic    mon_err;
  int      n_cmp = 0;
  int      n_bad = 0;
  bit      core_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_grid(input int nb, input int bd, input logic [W-1:0] pc);
    launch_t e;
    for (int b = 0; b < nb; b++) begin
      for (int t = 0; t < bd; t++) begin
        e.b = W'(b); e.t = W'(t); e.pc = pc; e.dim = W'(bd);
        exp_launch.push_back(e);
      end
    end
  endtask

  task automatic pulse_start(input int nb, input int bd, input logic [W-1:0] pc);
    @(negedge clk);
    num_blocks = W'(nb); block_dim_in = W'(bd); base_pc = pc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
  endtask

  // Scoreboard monitor: every launch/done the DUT presents is matched to the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (core_launch) begin
        if (exp_launch.size() == 0) begin
          check("unexpected_launch", core_launch, 0);
        end else begin
          mon_e = exp_launch.pop_front();
          check("launch_block_idx", block_idx, mon_e.b);
          check("launch_thread_idx", thread_idx, mon_e.t);
          check("launch_core_pc", core_pc, mon_e.pc);
          check("launch_block_dim", block_dim, mon_e.dim);
        end
      end
      if (done) begin
        if (exp_done_err.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          mon_err = exp_done_err.pop_front();
          check("done_err", err, mon_err);
        end
      end
    end
  end

  // Core model: answers each launch with core_done four cycles later.
  initial begin
    core_done_model = 1'b0;
    forever begin
      @(negedge clk);
      if (core_en && core_launch && !reset) begin
        repeat (4) @(negedge clk);
        core_done_model = 1'b1;
        @(negedge clk);
        core_done_model = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int first_err_k;
    int busy_cycles;
    reset = 1'b1; start = 1'b0; abort = 1'b0; core_done_stray = 1'b0;
    num_blocks = '0; block_dim_in = '0; base_pc = '0;

    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_launch", core_launch, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_block_idx", block_idx, 0);
    check("reset_thread_idx", thread_idx, 0);
    @(negedge clk);
    reset = 1'b0;

    // Nominal 2x3 kernel
    core_en = 1'b1;
    push_grid(2, 3, 16'h0010);
    exp_done_err.push_back(1'b0);
    pulse_start(2, 3, 16'h0010);
    check("nominal_busy", busy, 1);
    wait_idle(300, "nominal_finish");
    check("nominal_launches_left", exp_launch.size(), 0);
    check("nominal_done_left", exp_done_err.size(), 0);
    check("nominal_err", err, 0);
    core_en = 1'b0;

    // Empty kernels: zero blocks, then zero threads
    for (int v = 0; v < 2; v++) begin
      exp_done_err.push_back(1'b0);
      if (v == 0) pulse_start(0, 3, 16'h0020);
      else        pulse_start(2, 0, 16'h0020);
      check("empty_done_next_cycle", done, 1);
      busy_cycles = busy ? 1 : 0;
      repeat (4) begin
        @(negedge clk);
        if (busy) busy_cycles++;
      end
      check("empty_busy_cycles", busy_cycles, 1);
      check("empty_done_left", exp_done_err.size(), 0);
    end

    // Watchdog timeout with no core response
    push_grid(1, 1, 16'h0030);
    exp_done_err.push_back(1'b1);
    pulse_start(1, 1, 16'h0030);
    first_err_k = -1;
    for (int k = 1; k <= 40; k++) begin
      if (err) begin
        first_err_k = k;
        check("wd_done_with_err", done, 1);
        break;
      end
      @(negedge clk);
    end
    check("wd_err_cycle", first_err_k, 10);
    @(negedge clk);
    check("wd_err_sticky", err, 1);
    check("wd_idle", busy, 0);
    exp_done_err.push_back(1'b0);
    pulse_start(0, 4, 16'h0000);
    check("wd_err_cleared_by_start", err, 0);
    repeat (2) @(negedge clk);

    // Stray start/core_done events must not perturb a 1x2 kernel
    core_en = 1'b1;
    push_grid(1, 2, 16'h0040);
    exp_done_err.push_back(1'b0);
    pulse_start(1, 2, 16'h0040);
    core_done_stray = 1'b1;
    @(negedge clk);
    core_done_stray = 1'b0;
    @(negedge clk);
    num_blocks = 16'd5; block_dim_in = 16'd5; base_pc = 16'h0099; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_idle(300, "stray_finish");
    core_en = 1'b0;
    core_done_stray = 1'b1;
    @(negedge clk);
    core_done_stray = 1'b0;
    repeat (4) @(negedge clk);
    check("stray_block_idx", block_idx, 0);
    check("stray_thread_idx", thread_idx, 1);
    check("stray_core_pc", core_pc, 16'h0040);
    check("stray_launches_left", exp_launch.size(), 0);
    check("stray_done_left", exp_done_err.size(), 0);

    // Abort in the third RUN cycle: no done, back to IDLE
    exp_launch.push_back('{b: 16'd0, t: 16'd0, pc: 16'h0050, dim: 16'd2});
    pulse_start(2, 2, 16'h0050);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", busy, 0);
    repeat (5) @(negedge clk);
    check("abort_still_idle", busy, 0);
    check("abort_launches_left", exp_launch.size(), 0);

    // Reset mid-RUN of a new kernel
    exp_launch.push_back('{b: 16'd0, t: 16'd0, pc: 16'h0060, dim: 16'd3});
    pulse_start(1, 3, 16'h0060);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_launch", core_launch, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_core_pc", core_pc, 0);
    check("rst_block_dim", block_dim, 0);
    check("rst_block_idx", block_idx, 0);
    check("rst_thread_idx", thread_idx, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_idle", busy, 0);
    check("final_launches_left", exp_launch.size(), 0);
    check("final_done_left", exp_done_err.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kernel_dispatcher.md
KERNEL_DISPATCHER -- requirements
Module: kernel_dispatcher

Interface
REQ-001 Parameter WIDTH, default 16: width of the PC, count and index buses.
REQ-002 Parameter WATCHDOG_CYCLES, default 1024: maximum number of RUN cycles allowed per thread before timeout.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: kernel launch request, sampled in IDLE only.
REQ-006 Port num_blocks, input, WIDTH: block count, latched on the accepted start.
REQ-007 Port block_dim_in, input, WIDTH: threads per block, latched on the accepted start.
REQ-008 Port base_pc, input, WIDTH: kernel entry PC, latched on the accepted start.
REQ-009 Port abort, input, 1: cancels a running kernel.
REQ-010 Port core_done, input, 1: one-cycle pulse from the core marking thread completion.
REQ-011 Port core_launch, output, 1: one-cycle pulse telling the core to load core_pc and begin.
REQ-012 Port core_pc, output, WIDTH: latched base_pc.
REQ-013 Port block_idx, output, WIDTH: current block index, fed to reg_file.
REQ-014 Port block_dim, output, WIDTH: latched block_dim_in, fed to reg_file.
REQ-015 Port thread_idx, output, WIDTH: current thread index, fed to reg_file.
REQ-016 Port busy, output, 1: high whenever state is not IDLE.
REQ-017 Port done, output, 1: one-cycle completion pulse.
REQ-018 Port err, output, 1: sticky watchdog timeout flag.

Function
REQ-019 The FSM SHALL have the states IDLE, LAUNCH, RUN, ADVANCE and FIN.
REQ-020 IDLE with start=1: latch the inputs, set block_idx=0, thread_idx=0 and err=0; go to FIN if num_blocks==0 or block_dim_in==0, otherwise go to LAUNCH.
REQ-021 start SHALL be ignored in every state other than IDLE.
REQ-022 LAUNCH: core_launch=1 for exactly that cycle, watchdog cleared to 0, next state RUN.
REQ-023 RUN with core_done=1: next state ADVANCE.
REQ-024 RUN with core_done=0 and watchdog==WATCHDOG_CYCLES-1: set err=1 and go to FIN.
REQ-025 RUN with core_done=0 otherwise: increment the watchdog.
REQ-026 core_done SHALL be ignored outside RUN, including a core_done in the LAUNCH cycle.
REQ-027 ADVANCE when thread_idx != block_dim-1: thread_idx+1, next state LAUNCH.
REQ-028 ADVANCE when thread_idx == block_dim-1 and block_idx != num_blocks-1: thread_idx=0, block_idx+1, next state LAUNCH.
REQ-029 ADVANCE when both indices are at their last value: indices hold, next state FIN.
REQ-030 FIN: done=1 for exactly that cycle, next state IDLE.
REQ-031 abort=1 in any non-IDLE state SHALL go to IDLE on the next edge with no done pulse; abort has priority over every other transition.
REQ-032 Latency: core_launch is asserted 1 cycle after the start edge, and 2 cycles after the edge sampling core_done.
REQ-033 Exactly num_blocks*block_dim core_launch pulses SHALL occur per kernel with no timeout or abort; index order is thread-fastest.
REQ-034 Index arithmetic SHALL be unsigned WIDTH-bit; no wrap past the last value is possible, by REQ-029.
REQ-035 Outputs core_launch, done and busy SHALL be decoded from the registered state.
REQ-036 All other outputs SHALL be registers.

Reset
REQ-037 Reset SHALL force state=IDLE and every output register to 0, immediately and without waiting for a clock edge.
REQ-038 Reset mid-kernel SHALL discard the kernel with no done pulse and no further core_launch.

Structure
REQ-039 Package gpu_pkg SHALL hold the dispatch_state_t enum and the WIDTH default constant.
REQ-040 One sub-module, watchdog_timer (clear, enable, expired), SHALL implement the RUN watchdog.

Verification
REQ-041 Nominal kernel: num_blocks=2, block_dim=3, base_pc=0x0010, core_done 4 cycles after each launch -> 6 launches with (block_idx, thread_idx) = (0,0)(0,1)(0,2)(1,0)(1,1)(1,2), core_pc=0x0010 on each, one done pulse, err=0.
REQ-042 Empty kernel: start with num_blocks=0, then separately with block_dim_in=0 -> no core_launch, done 1 cycle after start, busy high for exactly 1 cycle.
REQ-043 Watchdog: WATCHDOG_CYCLES=8, core_done never asserted -> err=1 after 8 RUN cycles, then a done pulse; next start clears err.
REQ-044 Stray events: start pulses while busy, plus core_done in a LAUNCH cycle and in IDLE -> no effect on indices or launch count.
REQ-045 Abort and reset: abort in the third RUN, then reset asserted mid-RUN of a new kernel -> IDLE, no done pulse, all outputs 0 under reset.
